branch_sequencer: RTL and testbench
===================================

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 2: cycles each write strobe is held high, then held low, toward the branch unit.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles spent in any wait state before abort.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 aclk  in  1  sole clock, all logic on rising edge.
REQ-005 areset  in  1  synchronous active-high reset.
REQ-006 s_valid  in  1  command valid.
REQ-007 s_ready  out  1  command accept; transfer when s_valid & s_ready.
REQ-008 s_op  in  2  00 NOP, 01 SET_FLAGS, 10 SET_TARGET, 11 STEP.
REQ-009 s_operand  in  16  SET_FLAGS uses [3:0]; SET_TARGET uses [15:0]; others ignore it.
REQ-010 m_enable  out  1  branch-unit enable.
REQ-011 m_write_branch / m_write_flags  out  1 each  branch-unit write enables.
REQ-012 m_strobe  out  1  branch-unit advance pulse.
REQ-013 m_check_flags  out  4  flag mask to the branch unit.
REQ-014 m_branch  out  16  branch target to the branch unit.
REQ-015 m_ready  in  1  branch-unit readiness.
REQ-016 m_program_counter  in  16  branch-unit program counter.
REQ-017 done  out  1  one-cycle completion pulse.
REQ-018 pc_out  out  16  program counter captured at last STEP completion.
REQ-019 error  out  1  sticky timeout flag.

Function
REQ-020 FSM states SHALL be IDLE, WR_HOLD, WR_CLEAR, STROBE, WAIT_BUSY, WAIT_READY.
REQ-021 s_ready SHALL be 1 exactly when state is IDLE and areset is 0; commands are accepted only in IDLE.
REQ-022 m_enable SHALL be 1 in every cycle after reset deasserts.
REQ-023 Accept cycle T: SET_FLAGS loads m_check_flags <= s_operand[3:0]; SET_TARGET loads m_branch <= s_operand; both go to WR_HOLD; STEP goes to STROBE; NOP stays IDLE and pulses done at T+1.
REQ-024 WR_HOLD: the matching write enable SHALL be 1 for HOLD_CYCLES cycles (T+1..T+HOLD_CYCLES); then WR_CLEAR holds it 0 for HOLD_CYCLES cycles; then IDLE with done=1 in the IDLE entry cycle.
REQ-025 m_branch and m_check_flags SHALL stay constant except at SET_TARGET/SET_FLAGS accept.
REQ-026 STROBE: m_strobe SHALL be 1 for exactly one cycle, in the first STROBE cycle with m_ready=1, then go to WAIT_BUSY.
REQ-027 WAIT_BUSY SHALL advance to WAIT_READY on first cycle with m_ready=0.
REQ-028 WAIT_READY SHALL, on first cycle with m_ready=1, load pc_out <= m_program_counter, enter IDLE, pulse done in that IDLE cycle.
REQ-029 Write enables and m_strobe SHALL never be 1 simultaneously; at most one write enable is 1 in any cycle.
REQ-030 A timeout counter (width ceil(log2(TIMEOUT+1))) SHALL clear on entering STROBE, WAIT_BUSY or WAIT_READY and increment each cycle there; reaching TIMEOUT forces IDLE, error <= 1, no done pulse, pc_out unchanged.
REQ-031 error SHALL clear only on reset; operation continues normally after an error.
REQ-032 done SHALL never be 1 in two consecutive cycles unless NOP commands are back to back.

Reset
REQ-033 While areset=1 at a clock edge: state IDLE, s_ready 0, m_enable 0, all write enables and m_strobe 0, m_check_flags 0x0, m_branch 0x0000, pc_out 0x0000, done 0, error 0, timeout counter 0.
REQ-034 Reset asserted mid-command SHALL abort it at the next edge with no done pulse.

Verification
REQ-035 SET_TARGET 0x1234 accepted at T -> m_branch=0x1234 from T+1; m_write_branch=1 at T+1,T+2, 0 at T+3,T+4; done=1 at T+5 with s_ready=1.
REQ-036 SET_FLAGS 0x0005 -> m_check_flags=4'b0101; m_write_flags same timing as REQ-035; m_write_branch stays 0.
REQ-037 STEP with m_ready=1, model drops m_ready for 3 cycles then raises it with m_program_counter=0x0042 -> single m_strobe pulse at T+1, pc_out=0x0042, done one cycle.
REQ-038 STEP with m_ready held 1 forever -> after TIMEOUT cycles in WAIT_BUSY: error=1, no done, pc_out unchanged, s_ready=1.
REQ-039 areset=1 during WR_HOLD of SET_TARGET -> next cycle all outputs at REQ-033 values, no done.
REQ-040 Back-to-back NOP, NOP with s_valid held 1 -> accepted at T and T+1, done at T+1 and T+2.

Source files
------------

// File: rtl/branch_sequencer.sv
// -----------------------------------------------------------------------------
// branch_sequencer
//
// Turns a simple command stream into the handshake sequence a branch unit
// expects. Each accepted command is one of:
//   NOP        : no branch-unit activity, done pulses on the next cycle
//   SET_FLAGS  : load the flag mask, hold m_write_flags high then low
//   SET_TARGET : load the branch target, hold m_write_branch high then low
//   STEP       : one m_strobe pulse, then wait for the branch unit to go busy
//                (m_ready low) and ready again, then capture its PC
// Every wait state (STROBE, WAIT_BUSY, WAIT_READY) is bounded by TIMEOUT
// cycles; an expiry returns to IDLE without done and sets the sticky error.
//
// Ports
//   aclk, areset        clock, synchronous active-high reset
//   s_valid/s_ready     command handshake, s_op selects the command and
//   s_op, s_operand     s_operand carries its data
//   m_enable            branch-unit enable, high whenever out of reset
//   m_write_branch      write enable for the branch target
//   m_write_flags       write enable for the flag mask
//   m_strobe            single-cycle advance pulse
//   m_check_flags       flag mask register
//   m_branch            branch target register
//   m_ready             branch-unit readiness
//   m_program_counter   branch-unit program counter
//   done                one-cycle completion pulse
//   pc_out              program counter captured at the last completed STEP
//   error               sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module branch_sequencer #(
    parameter int HOLD_CYCLES = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [1:0]  s_op,
    input  logic [15:0] s_operand,
    output logic        m_enable,
    output logic        m_write_branch,
    output logic        m_write_flags,
    output logic        m_strobe,
    output logic [3:0]  m_check_flags,
    output logic [15:0] m_branch,
    input  logic        m_ready,
    input  logic [15:0] m_program_counter,
    output logic        done,
    output logic [15:0] pc_out,
    output logic        error
);

    localparam int HW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_HOLD,
        WR_CLEAR,
        STROBE,
        WAIT_BUSY,
        WAIT_READY
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP        = 2'b00,
        OP_SET_FLAGS  = 2'b01,
        OP_SET_TARGET = 2'b10,
        OP_STEP       = 2'b11
    } op_e;

    state_e          state_q, state_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [3:0]      flags_q, flags_d;
    logic [15:0]     branch_q, branch_d;
    logic            sel_branch_q, sel_branch_d;  // which write enable the hold phase drives
    logic [15:0]     pc_q, pc_d;
    logic            done_q, done_d;
    logic            error_q, error_d;

    // Combinational handshake: reset must block acceptance in the same cycle.
    assign s_ready       = (state_q == IDLE) && !areset;
    assign m_enable      = !areset;
    assign m_check_flags = flags_q;
    assign m_branch      = branch_q;
    assign pc_out        = pc_q;
    assign done          = done_q;
    assign error         = error_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; a missing default here would infer a latch.
        state_d        = state_q;
        hold_d         = hold_q;
        tmo_d          = tmo_q;
        flags_d        = flags_q;
        branch_d       = branch_q;
        sel_branch_d   = sel_branch_q;
        pc_d           = pc_q;
        done_d         = 1'b0;
        error_d        = error_q;
        m_write_branch = 1'b0;
        m_write_flags  = 1'b0;
        m_strobe       = 1'b0;

        unique case (state_q)
            IDLE: begin
                hold_d = '0;
                tmo_d  = '0;
                if (s_valid) begin
                    unique case (op_e'(s_op))
                        OP_NOP: done_d = 1'b1;
                        OP_SET_FLAGS: begin
                            flags_d      = s_operand[3:0];
                            sel_branch_d = 1'b0;
                            state_d      = WR_HOLD;
                        end
                        OP_SET_TARGET: begin
                            branch_d     = s_operand;
                            sel_branch_d = 1'b1;
                            state_d      = WR_HOLD;
                        end
                        OP_STEP: state_d = STROBE;
                        default: ;
                    endcase
                end
            end

            WR_HOLD: begin
                m_write_branch = sel_branch_q;
                m_write_flags  = !sel_branch_q;
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = WR_CLEAR;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end

            WR_CLEAR: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end

            // In the three wait states progress wins over an expiring counter
            // in the same cycle; the counter restarts at each state entry.
            STROBE: begin
                if (m_ready) begin
                    m_strobe = 1'b1;
                    tmo_d    = '0;
                    state_d  = WAIT_BUSY;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = '0;
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            WAIT_BUSY: begin
                if (!m_ready) begin
                    tmo_d   = '0;
                    state_d = WAIT_READY;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = '0;
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            WAIT_READY: begin
                if (m_ready) begin
                    pc_d    = m_program_counter;
                    done_d  = 1'b1;
                    tmo_d   = '0;
                    state_d = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = '0;
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            tmo_q        <= '0;
            flags_q      <= '0;
            branch_q     <= '0;
            sel_branch_q <= 1'b0;
            pc_q         <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            tmo_q        <= tmo_d;
            flags_q      <= flags_d;
            branch_q     <= branch_d;
            sel_branch_q <= sel_branch_d;
            pc_q         <= pc_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_branch_sequencer
//
// Directed plus randomized commands against branch_sequencer. Expected values
// come from a command-level model: register images for flags/target/pc/error
// and cycle offsets from the accept cycle computed arithmetically for each
// command type.
// -----------------------------------------------------------------------------
module tb_branch_sequencer;

    localparam int HOLD = 2;
    localparam int TMO  = 16;

    logic        aclk;
    logic        areset;
    logic        s_valid;
    logic        s_ready;
    logic [1:0]  s_op;
    logic [15:0] s_operand;
    logic        m_enable;
    logic        m_write_branch;
    logic        m_write_flags;
    logic        m_strobe;
    logic [3:0]  m_check_flags;
    logic [15:0] m_branch;
    logic        m_ready;
    logic [15:0] m_program_counter;
    logic        done;
    logic [15:0] pc_out;
    logic        error;

    branch_sequencer #(
        .HOLD_CYCLES (HOLD),
        .TIMEOUT     (TMO)
    ) dut (
        .aclk              (aclk),
        .areset            (areset),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .s_op              (s_op),
        .s_operand         (s_operand),
        .m_enable          (m_enable),
        .m_write_branch    (m_write_branch),
        .m_write_flags     (m_write_flags),
        .m_strobe          (m_strobe),
        .m_check_flags     (m_check_flags),
        .m_branch          (m_branch),
        .m_ready           (m_ready),
        .m_program_counter (m_program_counter),
        .done              (done),
        .pc_out            (pc_out),
        .error             (error)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    // Model of the architecturally visible registers.
    logic [3:0]  exp_flags;
    logic [15:0] exp_branch;
    logic [15:0] exp_pc;
    logic        exp_error;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, outputs are sampled
    // 3 units after it.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".m_enable"}, m_enable, 1'b1);
        check({tag, ".flags"},    m_check_flags, exp_flags);
        check({tag, ".branch"},   m_branch, exp_branch);
        check({tag, ".pc_out"},   pc_out, exp_pc);
        check({tag, ".error"},    error, exp_error);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".s_ready"},  s_ready, 1'b0);
        check({tag, ".m_enable"}, m_enable, 1'b0);
        check({tag, ".wr_br"},    m_write_branch, 1'b0);
        check({tag, ".wr_fl"},    m_write_flags, 1'b0);
        check({tag, ".strobe"},   m_strobe, 1'b0);
        check({tag, ".flags"},    m_check_flags, 4'h0);
        check({tag, ".branch"},   m_branch, 16'h0000);
        check({tag, ".pc_out"},   pc_out, 16'h0000);
        check({tag, ".done"},     done, 1'b0);
        check({tag, ".error"},    error, 1'b0);
    endtask

    // Present a command in the current cycle and advance to accept+1.
    task automatic accept(input logic [1:0] op, input logic [15:0] operand, input string tag);
        s_valid   = 1'b1;
        s_op      = op;
        s_operand = operand;
        settle();
        check({tag, ".accept_ready"}, s_ready, 1'b1);
        check({tag, ".accept_done"},  done, 1'b0);
        tick();
        s_valid   = 1'b0;
        s_op      = 2'($urandom);
        s_operand = 16'($urandom);
    endtask

    task automatic do_nop(input string tag);
        accept(2'b00, 16'($urandom), tag);
        settle();
        check({tag, ".done"},    done, 1'b1);
        check({tag, ".s_ready"}, s_ready, 1'b1);
        check_regs(tag);
        tick();
    endtask

    // Write enable high for offsets 1..HOLD, low for HOLD+1..2*HOLD,
    // done and s_ready at offset 2*HOLD+1.
    task automatic do_set(input bit is_target, input logic [15:0] operand, input string tag);
        accept(is_target ? 2'b10 : 2'b01, operand, tag);
        if (is_target) exp_branch = operand;
        else           exp_flags  = operand[3:0];
        for (int k = 1; k <= 2 * HOLD + 1; k++) begin
            settle();
            check($sformatf("%s.wr_br@%0d", tag, k), m_write_branch, is_target && (k <= HOLD));
            check($sformatf("%s.wr_fl@%0d", tag, k), m_write_flags, !is_target && (k <= HOLD));
            check($sformatf("%s.strobe@%0d", tag, k), m_strobe, 1'b0);
            check($sformatf("%s.done@%0d", tag, k), done, k == 2 * HOLD + 1);
            check($sformatf("%s.ready@%0d", tag, k), s_ready, k == 2 * HOLD + 1);
            check_regs($sformatf("%s@%0d", tag, k));
            tick();
        end
    endtask

    // STEP: m_ready low for a cycles, high (strobe) at a+1, high for b more
    // cycles, low for l cycles, then high carrying pc. Done follows one cycle
    // after that final high cycle.
    task automatic do_step(input int a, input int b, input int l, input logic [15:0] pc,
                           input string tag);
        int strobe_k;
        int pc_k;
        int done_k;
        strobe_k = a + 1;
        pc_k     = a + b + l + 2;
        done_k   = pc_k + 1;
        accept(2'b11, 16'($urandom), tag);
        for (int k = 1; k <= done_k; k++) begin
            if (k < strobe_k)                   m_ready = 1'b0;
            else if (k <= strobe_k + b)         m_ready = 1'b1;
            else if (k < pc_k)                  m_ready = 1'b0;
            else if (k == pc_k)                 m_ready = 1'b1;
            else                                m_ready = 1'($urandom);
            m_program_counter = (k == pc_k) ? pc : 16'($urandom);
            if (k == done_k) exp_pc = pc;
            settle();
            check($sformatf("%s.strobe@%0d", tag, k), m_strobe, k == strobe_k);
            check($sformatf("%s.wr@%0d", tag, k), m_write_branch | m_write_flags, 1'b0);
            check($sformatf("%s.done@%0d", tag, k), done, k == done_k);
            check($sformatf("%s.ready@%0d", tag, k), s_ready, k == done_k);
            check_regs($sformatf("%s@%0d", tag, k));
            tick();
        end
        m_ready = 1'b1;
    endtask

    // STEP with m_ready stuck high: strobe at +1, WAIT_BUSY for TMO cycles,
    // back in IDLE at +TMO+2 with error set and no done.
    task automatic do_timeout(input string tag);
        m_ready = 1'b1;
        accept(2'b11, 16'h0000, tag);
        for (int k = 1; k <= TMO + 2; k++) begin
            m_program_counter = 16'($urandom);
            if (k == TMO + 2) exp_error = 1'b1;
            settle();
            check($sformatf("%s.strobe@%0d", tag, k), m_strobe, k == 1);
            check($sformatf("%s.done@%0d", tag, k), done, 1'b0);
            check($sformatf("%s.ready@%0d", tag, k), s_ready, k == TMO + 2);
            check_regs($sformatf("%s@%0d", tag, k));
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        areset            = 1'b1;
        s_valid           = 1'b0;
        s_op              = 2'b00;
        s_operand         = 16'h0000;
        m_ready           = 1'b1;
        m_program_counter = 16'h0000;
        exp_flags         = 4'h0;
        exp_branch        = 16'h0000;
        exp_pc            = 16'h0000;
        exp_error         = 1'b0;

        // Reset state.
        repeat (3) tick();
        settle();
        check_reset_outputs("reset");
        areset = 1'b0;
        settle();
        check("post_reset.s_ready",  s_ready, 1'b1);
        check("post_reset.m_enable", m_enable, 1'b1);
        tick();

        // Directed scenarios.
        do_set(1'b1, 16'h1234, "set_target");
        do_set(1'b0, 16'h0005, "set_flags");
        check("set_flags.mask", m_check_flags, 4'b0101);
        do_step(0, 0, 3, 16'h0042, "step");
        check("step.pc_out", pc_out, 16'h0042);
        do_timeout("timeout");
        check("timeout.pc_kept", pc_out, 16'h0042);
        do_nop("nop_after_err");
        do_set(1'b1, 16'hBEEF, "set_after_err");
        do_step(2, 1, 1, 16'h7A5C, "step_after_err");

        // Back-to-back NOPs with s_valid held high.
        s_valid = 1'b1;
        s_op    = 2'b00;
        settle();
        check("nop2.accept0_ready", s_ready, 1'b1);
        check("nop2.accept0_done",  done, 1'b0);
        tick();
        settle();
        check("nop2.accept1_ready", s_ready, 1'b1);
        check("nop2.done1",         done, 1'b1);
        tick();
        s_valid = 1'b0;
        settle();
        check("nop2.done2", done, 1'b1);
        tick();
        settle();
        check("nop2.done3", done, 1'b0);
        tick();

        // Reset during WR_HOLD of a SET_TARGET.
        accept(2'b10, 16'hA5A5, "rst_mid");
        settle();
        check("rst_mid.wr_br", m_write_branch, 1'b1);
        areset = 1'b1;
        tick();
        settle();
        check_reset_outputs("rst_mid");
        areset     = 1'b0;
        exp_flags  = 4'h0;
        exp_branch = 16'h0000;
        exp_pc     = 16'h0000;
        exp_error  = 1'b0;
        settle();
        check("rst_mid.ready_after", s_ready, 1'b1);
        tick();
        settle();
        check("rst_mid.no_done", done, 1'b0);
        check("rst_mid.no_wr",   m_write_branch, 1'b0);
        check_regs("rst_mid");
        tick();

        // Randomized command stream.
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(3, 0))
                0: do_nop($sformatf("rnd%0d.nop", i));
                1: do_set(1'b0, 16'($urandom), $sformatf("rnd%0d.flags", i));
                2: do_set(1'b1, 16'($urandom), $sformatf("rnd%0d.target", i));
                default: do_step($urandom_range(4, 0), $urandom_range(4, 0),
                                 $urandom_range(5, 1), 16'($urandom),
                                 $sformatf("rnd%0d.step", i));
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
